// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared constants for the instruction/data memory port arbiter
//   ADDR_LEN / XLEN : address and register-file word widths used as port defaults
//   arb_state_e     : arbiter FSM encoding
//   owner_e         : which requester holds the downstream port
package mem_port_arbiter_pkg;
  localparam int ADDR_LEN = 32;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;
  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of data grants taken while a fetch was waiting
//   clk, rst    : clock, asynchronous active-low reset
//   inc_i       : data granted while i_req pending
//   clr_i       : instruction granted, or data granted with no fetch pending
//   limit_hit_o : count has reached LIMIT, the fetch must win the next tie
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_hit_o
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] count_q, count_d;
  assign limit_hit_o = count_q == CW'(LIMIT);
  always_comb count_d = clr_i ? '0 : (inc_i && !limit_hit_o) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM controller between the fetch port and the data port
//   clk, rst                        : clock, asynchronous active-low reset
//   i_req/i_addr -> i_ready/i_rdata : instruction read port
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata : data read/write port
//   m_req/m_we/m_addr/m_wdata <- m_ready/m_rdata : downstream controller handshake
//   busy, owner                     : transaction in flight, and who owns it
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int DATA_W = XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);
  arb_state_e state_q;
  owner_e owner_q;
  logic m_req_q, m_we_q, i_ready_q, d_ready_q, busy_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, i_rdata_q, d_rdata_q;
  logic idle, limit_hit, grant_i, grant_d;
  assign idle = state_q == ARB_IDLE;
  // data wins ties unless it has already starved the fetch port STARVE_LIMIT times
  assign grant_i = idle & i_req & (~d_req | limit_hit);
  assign grant_d = idle & d_req & ~grant_i;
  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (grant_d & i_req),
    .clr_i      (grant_i | (grant_d & ~i_req)),
    .limit_hit_o(limit_hit)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_INSTR;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        ARB_IDLE:
          if (grant_i | grant_d) begin
            state_q  <= ARB_GRANT;
            m_req_q  <= 1'b1;
            busy_q   <= 1'b1;
            owner_q  <= grant_d ? OWNER_DATA : OWNER_INSTR;
            m_we_q   <= grant_d & d_we;
            m_addr_q <= grant_d ? d_addr : i_addr;
            if (grant_d) m_wdata_q <= d_wdata;
          end
        ARB_GRANT:
          if (m_ready) begin
            state_q <= ARB_RESP;
            m_req_q <= 1'b0;
            if (owner_q == OWNER_INSTR) begin
              i_ready_q <= 1'b1;
              i_rdata_q <= m_rdata;
            end else begin
              d_ready_q <= 1'b1;
              if (!m_we_q) d_rdata_q <= m_rdata;
            end
          end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ready = i_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_ready = d_ready_q;
  assign d_rdata = d_rdata_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external-memory controller between the instruction-fetch port and the MEM-stage data port, so that instructions and data can live in the same SRAM. It sits between IF/MEM stages and the SRAM controller. It latches one request at a time and drives the downstream req/ready handshake. It returns a registered one-cycle ready pulse and the read data to the winning port. Data has fixed priority, with an anti-starvation counter that forces an instruction grant.

## Interface
- `ADDR_W`, default 32: byte address width for both ports and downstream.
- `DATA_W`, default 32: data word width.
- `STARVE_LIMIT`, default 4: consecutive data grants, with `i_req` pending, after which instruction wins.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction read request, held until `i_ready`.
- `i_addr`  in  ADDR_W  instruction address, stable while `i_req`.
- `i_ready`  out  1  one-cycle pulse: instruction access done.
- `i_rdata`  out  DATA_W  fetched word, valid with `i_ready`, held until next instruction response.
- `d_req`  in  1  data request, held until `d_ready`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_ready`  out  1  one-cycle pulse: data access done (feeds pipeline `mem_ready` logic).
- `d_rdata`  out  DATA_W  load data, updated only on read responses.
- `m_req`  out  1  downstream request, registered, held until `m_ready`.
- `m_we`, `m_addr`, `m_wdata`  out  1/ADDR_W/DATA_W  latched command fields, stable while `m_req`.
- `m_ready`  in  1  downstream completion pulse.
- `m_rdata`  in  DATA_W  downstream read data, valid with `m_ready`.
- `busy`  out  1  state != IDLE.
- `owner`  out  1  0 = instruction, 1 = data; meaningful while `busy`.

## Operation
- FSM states: IDLE, GRANT, RESP.
- **IDLE**: sample `i_req`/`d_req`.
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant it.
  - Both asserted: data wins, unless `streak == STARVE_LIMIT`, in which case instruction wins.
  - On a grant: latch the command into `m_*`, set `owner`, go to GRANT.
- **GRANT**: `m_req` = 1 with frozen fields. On `m_ready`: capture `m_rdata` into the owner's rdata register. Data writes do not capture. Go to RESP.
- **RESP**: owner's ready = 1 for exactly this cycle, `m_req` = 0. Go to IDLE.
- A request still high in IDLE after its ready pulse is a new request. Requesters deassert `req` no later than the cycle after the ready pulse.
- `streak` counter, width clog2(STARVE_LIMIT+1), saturating:
  - +1 on a data grant while `i_req` = 1.
  - Cleared on any instruction grant.
  - Cleared on a data grant with `i_req` = 0.
- `i_addr`/`d_*` changes while their request is in GRANT are ignored; the latched copy is used.
- Reset values: state IDLE; `m_req`, `m_we`, `i_ready`, `d_ready`, `busy`, `owner` = 0; `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0; `streak` = 0.
- Reset mid-transaction abandons the access. The downstream controller shares `rst` and aborts too. No ready pulse is issued.
- `m_ready` outside GRANT is ignored.

## Timing
- Request seen in IDLE at cycle 0 -> `m_req` high from cycle 1.
- `m_ready` at cycle k -> requester ready pulse and rdata at cycle k+1 -> IDLE at k+2. The earliest next grant decision is made in k+2, with `m_req` high again from k+3.
- Total latency is downstream latency + 2 cycles. Minimum with `m_ready` in cycle 1: ready at cycle 2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared constants package gets:
  - the FSM state encoding (`ARB_IDLE`, `ARB_GRANT`, `ARB_RESP`);
  - the owner encoding (`OWNER_INSTR`=0, `OWNER_DATA`=1).
- The width defaults come from the existing address/register-file length constants.
- One natural sub-module: `arb_starve_counter`, the saturating streak counter with inc/clr inputs and a `limit_hit` output.
- At integration, `d_ready` drives the existing freeze-on-not-ready path.
- IF freeze additionally ORs `~i_ready` while `i_req` is high.

## Test plan
- **Lone fetch**: `i_req`=1, `i_addr`=0x40; downstream returns 0xE3A01005 after 3 cycles. Required: `m_req` high cycles 1..3, `i_ready` pulse cycle 4, `i_rdata`=0xE3A01005, `owner`=0.
- **Simultaneous requests**: `i_req`=`d_req`=1 in IDLE with `d_we`=0, `d_addr`=0x100. Required: data granted first, `d_ready` pulse; instruction granted on the next IDLE.
- **Starvation** (`STARVE_LIMIT`=4): `i_req` held, `d_req` re-issued continuously. Required: exactly 4 data grants, then an instruction grant, then `streak`=0.
- **Write**: `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF. Required: `m_we`=1, `m_addr`=0x200, `m_wdata`=0xDEADBEEF held stable through GRANT; `d_rdata` unchanged after `d_ready`.
- **Input change during GRANT**: change `d_addr` 0x200 -> 0x300 during GRANT. Required: `m_addr` stays 0x200.
- **Reset mid-GRANT**: assert `rst`=0 asynchronously mid-GRANT. Required: all outputs 0 immediately, no ready pulse after release, and a later stray `m_ready` is ignored.
